// File: rtl/ov7670_capture_scaled.sv
// OV7670 capture: synchronises camera pins into clk, assembles 2-byte pixels, decimates/clips,
// and emits frame buffer writes (addr/dout/we) plus frame and line-error status.
module ov7670_capture_scaled #(
  parameter int C_SRC_COLS    = 640,
  parameter int C_SRC_ROWS    = 480,
  parameter int C_IMG_COLS    = 320,
  parameter int C_IMG_ROWS    = 240,
  parameter int C_NB_IMG_PXLS = 17,
  parameter int C_NB_RED      = 4,
  parameter int C_NB_GREEN    = 4,
  parameter int C_NB_BLUE     = 4,
  parameter int C_NB_BUF      = C_NB_RED + C_NB_GREEN + C_NB_BLUE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pclk,
  input  logic                     vsync,
  input  logic                     href,
  input  logic [7:0]               data,
  input  logic                     enable,
  input  logic                     rgbmode,
  input  logic                     swap_r_b,
  input  logic [1:0]               decim,
  output logic [C_NB_IMG_PXLS-1:0] addr,
  output logic [C_NB_BUF-1:0]      dout,
  output logic                     we,
  output logic                     frame_done,
  output logic [7:0]               frame_cnt,
  output logic                     line_err
);

  localparam int CW = 16;
  localparam logic [CW-1:0] SRC_COLS_L = CW'(C_SRC_COLS);
  localparam logic [CW-1:0] SRC_ROWS_L = CW'(C_SRC_ROWS);
  localparam logic [CW-1:0] IMG_COLS_L = CW'(C_IMG_COLS);
  localparam logic [CW-1:0] IMG_ROWS_L = CW'(C_IMG_ROWS);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE} state_t;

  state_t          state;
  logic [2:0]      pclk_sr, href_sr, vsync_sr;
  logic [7:0]      data_d1, data_d2;
  logic            mode_rgb, mode_swap;
  logic [1:0]      mode_dec;
  logic [CW-1:0]   src_col, src_row;
  logic            phase;
  logic [7:0]      byte0;

  logic            s1_vld;
  logic [CW-1:0]   s1_col, s1_row;
  logic [7:0]      s1_b0, s1_b1;

  logic            pclk_rise, href_lvl, href_rise, href_fall, vsync_rise, vsync_fall;
  logic            pix_evt, phase_nxt, keep;
  logic [CW-1:0]   dec_mask, dst_col, dst_row;
  logic [4:0]      r5, b5;
  logic [5:0]      g6;
  logic [C_NB_BUF-1:0]      dout_c;
  logic [C_NB_IMG_PXLS-1:0] addr_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_sr  <= '0;
      href_sr  <= '0;
      vsync_sr <= '0;
      data_d1  <= '0;
      data_d2  <= '0;
    end else begin
      pclk_sr  <= {pclk_sr[1:0], pclk};
      href_sr  <= {href_sr[1:0], href};
      vsync_sr <= {vsync_sr[1:0], vsync};
      data_d1  <= data;
      data_d2  <= data_d1;
    end
  end

  assign pclk_rise  = pclk_sr[1] & ~pclk_sr[2];
  assign href_lvl   = href_sr[1];
  assign href_rise  = href_sr[1] & ~href_sr[2];
  assign href_fall  = ~href_sr[1] & href_sr[2];
  assign vsync_rise = vsync_sr[1] & ~vsync_sr[2];
  assign vsync_fall = ~vsync_sr[1] & vsync_sr[2];

  // A pclk edge coinciding with href falling still belongs to the ending line.
  assign pix_evt   = (state == CAPTURE) & enable & pclk_rise & (href_lvl | href_fall)
                     & ~vsync_rise & ~href_rise;
  assign phase_nxt = pix_evt ? ~phase : phase;

  always_comb begin
    dec_mask = (CW'(1) << mode_dec) - CW'(1);
    dst_col  = src_col >> mode_dec;
    dst_row  = src_row >> mode_dec;
    keep     = ((src_col & dec_mask) == '0) && ((src_row & dec_mask) == '0)
               && (src_col < SRC_COLS_L) && (src_row < SRC_ROWS_L)
               && (dst_col < IMG_COLS_L) && (dst_row < IMG_ROWS_L);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mode_rgb   <= 1'b1;
      mode_swap  <= 1'b0;
      mode_dec   <= 2'd0;
      src_col    <= '0;
      src_row    <= '0;
      phase      <= 1'b0;
      byte0      <= '0;
      s1_vld     <= 1'b0;
      s1_col     <= '0;
      s1_row     <= '0;
      s1_b0      <= '0;
      s1_b1      <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      s1_vld     <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        phase <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_FRAME;
          WAIT_FRAME: begin
            if (vsync_fall) begin
              state     <= CAPTURE;
              mode_rgb  <= rgbmode;
              mode_swap <= swap_r_b;
              mode_dec  <= (decim == 2'd3) ? 2'd2 : decim;
              src_col   <= '0;
              src_row   <= '0;
              phase     <= 1'b0;
            end
          end
          CAPTURE: begin
            if (vsync_rise) begin
              state      <= WAIT_FRAME;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              phase      <= 1'b0;
            end else if (href_rise) begin
              src_col <= '0;
              phase   <= 1'b0;
            end else begin
              if (pix_evt) begin
                if (!phase) begin
                  byte0 <= data_d2;
                end else begin
                  s1_vld <= keep;
                  s1_col <= dst_col;
                  s1_row <= dst_row;
                  s1_b0  <= byte0;
                  s1_b1  <= data_d2;
                  if (src_col != '1) src_col <= src_col + CW'(1);
                end
              end
              if (href_fall) begin
                if (src_row != '1) src_row <= src_row + CW'(1);
                if (phase_nxt) line_err <= 1'b1;
                phase <= 1'b0;
              end else begin
                phase <= phase_nxt;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    r5 = mode_swap ? s1_b1[4:0] : s1_b0[7:3];
    g6 = {s1_b0[2:0], s1_b1[7:5]};
    b5 = mode_swap ? s1_b0[7:3] : s1_b1[4:0];
    if (mode_rgb)
      dout_c = C_NB_BUF'(((32'(r5) >> (5 - C_NB_RED)) << (C_NB_GREEN + C_NB_BLUE))
                       | ((32'(g6) >> (6 - C_NB_GREEN)) << C_NB_BLUE)
                       | (32'(b5) >> (5 - C_NB_BLUE)));
    else
      dout_c = C_NB_BUF'(32'(s1_b0) << (C_NB_BUF - 8));
    addr_c = C_NB_IMG_PXLS'(32'(s1_row) * 32'(C_IMG_COLS) + 32'(s1_col));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we   <= 1'b0;
      addr <= '0;
      dout <= '0;
    end else begin
      we <= s1_vld & enable;
      if (s1_vld) begin
        addr <= addr_c;
        dout <= dout_c;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture_scaled.sv
// Scoreboard bench: camera-side stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_ov7670_capture_scaled;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pclk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        enable = 1'b0, rgbmode = 1'b1, swap_r_b = 1'b0;
  logic [1:0]  decim = 2'd0;
  logic [2:0]  addr;
  logic [11:0] dout;
  logic        we, frame_done, line_err;
  logic [7:0]  frame_cnt;

  ov7670_capture_scaled #(
    .C_SRC_COLS(8), .C_SRC_ROWS(4), .C_IMG_COLS(4), .C_IMG_ROWS(2), .C_NB_IMG_PXLS(3),
    .C_NB_RED(4), .C_NB_GREEN(4), .C_NB_BLUE(4), .C_NB_BUF(12)
  ) dut (
    .clk(clk), .rst(rst), .pclk(pclk), .vsync(vsync), .href(href), .data(data),
    .enable(enable), .rgbmode(rgbmode), .swap_r_b(swap_r_b), .decim(decim),
    .addr(addr), .dout(dout), .we(we), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .line_err(line_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a;
    logic [11:0] d;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   fd_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (we) begin
      exp_t e;
      wr_count++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%0d dout=0x%0h required=no write", addr, dout);
      end else begin
        e = q.pop_front();
        chk("wr_addr", int'(addr), int'(e.a));
        chk("wr_dout", int'(dout), int'(e.d));
        chk("wr_latency", cyc - e.c, 4);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Source pixel (c,r) kept at address a under decimation dec for a 8x4 source / 4x2 image.
  function automatic bit mdl_keep(input int c, input int r, input int dec, output int a);
    int st;
    st = (dec == 0) ? 1 : (dec == 1) ? 2 : 4;
    a  = (r / st) * 4 + c / st;
    return (c % st == 0) && (r % st == 0) && (c < 8) && (r < 4) && (c / st < 4) && (r / st < 2);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit push, input logic [2:0] ea,
                           input logic [11:0] ed, input bit drop_href);
    exp_t e;
    tick;
    pclk = 1'b0;
    data = b;
    tick;
    tick;
    pclk = 1'b1;
    if (drop_href) href = 1'b0;
    if (push) begin
      e.a = ea;
      e.d = ed;
      e.c = cyc;
      q.push_back(e);
    end
    tick;
  endtask

  task automatic line_start;
    tick;
    href = 1'b1;
    tick;
    tick;
  endtask

  task automatic line_end;
    tick;
    href = 1'b0;
    repeat (3) tick;
  endtask

  task automatic send_line(input int row, input int ncols, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [11:0] ed, input int dec,
                           input bit coinc);
    int a;
    bit k;
    line_start();
    for (int c = 0; c < ncols; c++) begin
      k = mdl_keep(c, row, dec, a);
      send_byte(b0, 1'b0, 3'd0, 12'd0, 1'b0);
      send_byte(b1, k, a[2:0], ed, coinc && (c == ncols - 1));
    end
    if (coinc) repeat (3) tick;
    else line_end();
  endtask

  task automatic start_frame;
    wr_count = 0;
    vsync = 1'b1;
    repeat (4) tick;
    vsync = 1'b0;
    repeat (4) tick;
  endtask

  task automatic end_frame;
    repeat (6) tick;
    vsync = 1'b1;
    repeat (6) tick;
  endtask

  task automatic frame_checks(input string tag, input int exp_wr, input int exp_fd,
                              input int exp_cnt);
    chk({tag, "_writes"}, wr_count, exp_wr);
    chk({tag, "_pending"}, q.size(), 0);
    chk({tag, "_frame_done"}, fd_count, exp_fd);
    chk({tag, "_frame_cnt"}, int'(frame_cnt), exp_cnt);
  endtask

  task automatic run_frame(input int rows, input int cols, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [11:0] ed, input int dec,
                           input bit coinc);
    start_frame();
    for (int r = 0; r < rows; r++) send_line(r, cols, b0, b1, ed, dec, coinc);
    end_frame();
  endtask

  initial begin
    repeat (3) tick;
    chk("rst_addr", int'(addr), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_line_err", int'(line_err), 0);
    rst = 1'b1;
    enable = 1'b1;
    repeat (3) tick;

    // 1:1 RGB565, last pixel of each line completes as href drops
    run_frame(2, 4, 8'hF8, 8'h00, 12'hF00, 0, 1'b1);
    frame_checks("rgb", 8, 1, 1);

    swap_r_b = 1'b1;
    run_frame(2, 4, 8'hF8, 8'h00, 12'h00F, 0, 1'b0);
    frame_checks("swap", 8, 2, 2);
    swap_r_b = 1'b0;

    decim = 2'd1;
    run_frame(4, 8, 8'h07, 8'hE0, 12'h0F0, 1, 1'b0);
    frame_checks("dec2", 8, 3, 3);

    // full 8x4 source into a 4x2 image with no decimation: the rest is clipped
    decim = 2'd0;
    run_frame(4, 8, 8'h12, 8'h34, 12'h14A, 0, 1'b0);
    frame_checks("clip", 8, 4, 4);

    decim = 2'd3;
    run_frame(4, 8, 8'hF8, 8'h00, 12'hF00, 2, 1'b0);
    frame_checks("dec3", 2, 5, 5);

    decim = 2'd0;
    rgbmode = 1'b0;
    run_frame(2, 4, 8'hA5, 8'h10, 12'hA50, 0, 1'b0);
    frame_checks("yuv", 8, 6, 6);
    chk("line_err_clean", int'(line_err), 0);
    rgbmode = 1'b1;

    // odd-length line: two pixels plus a dangling byte
    start_frame();
    line_start();
    send_byte(8'hF8, 1'b0, 3'd0, 12'd0, 1'b0);
    send_byte(8'h00, 1'b1, 3'd0, 12'hF00, 1'b0);
    send_byte(8'hF8, 1'b0, 3'd0, 12'd0, 1'b0);
    send_byte(8'h00, 1'b1, 3'd1, 12'hF00, 1'b0);
    send_byte(8'hF8, 1'b0, 3'd0, 12'd0, 1'b0);
    line_end();
    send_line(1, 4, 8'hF8, 8'h00, 12'hF00, 0, 1'b0);
    end_frame();
    frame_checks("odd", 6, 7, 7);
    chk("line_err_set", int'(line_err), 1);

    run_frame(2, 4, 8'hF8, 8'h00, 12'hF00, 0, 1'b0);
    frame_checks("after_err", 8, 8, 8);
    chk("line_err_sticky", int'(line_err), 1);

    // capture disarmed mid-line
    start_frame();
    line_start();
    send_byte(8'hF8, 1'b0, 3'd0, 12'd0, 1'b0);
    send_byte(8'h00, 1'b1, 3'd0, 12'hF00, 1'b0);
    send_byte(8'hF8, 1'b0, 3'd0, 12'd0, 1'b0);
    send_byte(8'h00, 1'b1, 3'd1, 12'hF00, 1'b0);
    repeat (6) tick;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b0, 3'd0, 12'd0, 1'b0);
    line_end();
    end_frame();
    frame_checks("disable", 2, 8, 8);

    // reset mid-line
    enable = 1'b1;
    start_frame();
    line_start();
    send_byte(8'hF8, 1'b0, 3'd0, 12'd0, 1'b0);
    send_byte(8'h00, 1'b1, 3'd0, 12'hF00, 1'b0);
    send_byte(8'h12, 1'b0, 3'd0, 12'd0, 1'b0);
    send_byte(8'h34, 1'b1, 3'd1, 12'h14A, 1'b0);
    repeat (6) tick;
    chk("pre_rst_addr", int'(addr), 1);
    send_byte(8'hF8, 1'b0, 3'd0, 12'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_addr", int'(addr), 0);
    chk("mid_rst_dout", int'(dout), 0);
    chk("mid_rst_we", int'(we), 0);
    chk("mid_rst_frame_cnt", int'(frame_cnt), 0);
    chk("mid_rst_line_err", int'(line_err), 0);
    send_byte(8'h00, 1'b0, 3'd0, 12'd0, 1'b0);
    line_end();
    rst = 1'b1;
    repeat (4) tick;
    fd_count = 0;
    run_frame(2, 4, 8'hF8, 8'h00, 12'hF00, 0, 1'b0);
    frame_checks("post_rst", 8, 1, 1);
    chk("post_rst_line_err", int'(line_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
